// File: rtl/cpu_issue_ctrl_pkg.sv
// Shared types and default latencies for the decode->execute issue controller.
// CPU_FORWARDING_EN selects bypass-aware scoreboard loads (tracked latency reduced by ALU_LAT).
package cpu_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ALU  = 2'd1,
        CLS_MUL  = 2'd2,
        CLS_LOAD = 2'd3
    } instr_class_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } issue_state_t;

    localparam int DEF_NUM_REGS     = 32;
    localparam int DEF_REG_W        = 5;
    localparam int DEF_ALU_LAT      = 3;
    localparam int DEF_MUL_LAT      = 5;
    localparam int DEF_LOAD_LAT     = 4;
    localparam int DEF_FLUSH_CYCLES = 2;
    localparam int DEF_CNT_W        = 3;

`ifdef CPU_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

endpackage

// File: rtl/cpu_issue_ctrl_scoreboard.sv
// Per-register countdown of cycles until an in-flight write lands; reports source-busy and WAW.
// Purely combinational lookups; counters update every edge with the issue load taking priority.
module cpu_issue_ctrl_scoreboard
    import cpu_issue_ctrl_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_W    = DEF_REG_W,
    parameter int ALU_LAT  = DEF_ALU_LAT,
    parameter int MUL_LAT  = DEF_MUL_LAT,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] ra_i,
    input  logic             ra_used_i,
    input  logic [REG_W-1:0] rb_i,
    input  logic             rb_used_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic             rd_wr_i,
    input  instr_class_t     cls_i,
    input  logic             load_i,
    output logic             busy_a_o,
    output logic             busy_b_o,
    output logic             waw_o
);

    // With a bypass network only the part of the latency beyond the ALU stage is visible.
    localparam int FWD_SUB = FWD_EN ? ALU_LAT : 0;
    localparam logic [CNT_W-1:0] LAT_ALU  = CNT_W'(ALU_LAT - FWD_SUB);
    localparam logic [CNT_W-1:0] LAT_MUL  = CNT_W'(MUL_LAT - FWD_SUB);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LOAD_LAT - FWD_SUB);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic [CNT_W-1:0] lat;

    always_comb begin
        lat = '0;
        case (cls_i)
            CLS_ALU:  lat = LAT_ALU;
            CLS_MUL:  lat = LAT_MUL;
            CLS_LOAD: lat = LAT_LOAD;
            default:  lat = '0;
        endcase
    end

    assign busy_a_o = ra_used_i && (ra_i != '0) && (cnt_q[ra_i] != '0);
    assign busy_b_o = rb_used_i && (rb_i != '0) && (cnt_q[rb_i] != '0);
    assign waw_o    = rd_wr_i && (rd_i != '0) && (cnt_q[rd_i] > lat);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
        end
        if (load_i && rd_wr_i && (rd_i != '0)) begin
            cnt_d[rd_i] = lat;
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: rtl/cpu_issue_ctrl.sv
// Decode->execute issue controller: hazard stall, bubble insertion, post-branch flush sequencing.
// Optional CPU_FORWARDING_EN shortens scoreboard tracking to the non-bypassable latency.
module cpu_issue_ctrl
    import cpu_issue_ctrl_pkg::*;
#(
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int REG_W        = DEF_REG_W,
    parameter int ALU_LAT      = DEF_ALU_LAT,
    parameter int MUL_LAT      = DEF_MUL_LAT,
    parameter int LOAD_LAT     = DEF_LOAD_LAT,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dec_valid_i,
    input  logic [REG_W-1:0] dec_ra_i,
    input  logic             dec_ra_used_i,
    input  logic [REG_W-1:0] dec_rb_i,
    input  logic             dec_rb_used_i,
    input  logic [REG_W-1:0] dec_rd_i,
    input  logic             dec_rd_wr_i,
    input  instr_class_t     dec_class_i,
    input  logic             flush_req_i,
    output logic             issue_fire_o,
    output logic             issue_stall_o,
    output logic             bubble_o,
    output logic             flush_active_o,
    output logic [15:0]      stall_cnt_o
);

    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);

    issue_state_t    state_q;
    logic [FL_W-1:0] flush_cnt_q;
    logic [15:0]     stall_cnt_q;

    logic busy_a, busy_b, waw;
    logic in_flush, hazard, fire;

    cpu_issue_ctrl_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W),
        .ALU_LAT  (ALU_LAT),
        .MUL_LAT  (MUL_LAT),
        .LOAD_LAT (LOAD_LAT),
        .CNT_W    (CNT_W)
    ) u_scoreboard (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ra_i      (dec_ra_i),
        .ra_used_i (dec_ra_used_i),
        .rb_i      (dec_rb_i),
        .rb_used_i (dec_rb_used_i),
        .rd_i      (dec_rd_i),
        .rd_wr_i   (dec_rd_wr_i),
        .cls_i     (dec_class_i),
        .load_i    (fire),
        .busy_a_o  (busy_a),
        .busy_b_o  (busy_b),
        .waw_o     (waw)
    );

    assign in_flush = (state_q == S_FLUSH);
    assign hazard   = dec_valid_i && (busy_a || busy_b || waw);
    // The cycle carrying flush_req is already a flush bubble, ahead of any issue.
    assign fire     = !rst_i && dec_valid_i && !hazard && !in_flush && !flush_req_i;

    assign issue_fire_o   = fire;
    assign issue_stall_o  = !rst_i && (hazard || in_flush || flush_req_i);
    assign bubble_o       = !fire;
    assign flush_active_o = !rst_i && (in_flush || flush_req_i);
    assign stall_cnt_o    = stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_RUN;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (hazard && !in_flush && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (flush_req_i) begin
                state_q     <= S_FLUSH;
                flush_cnt_q <= FL_W'(FLUSH_CYCLES);
            end else begin
                case (state_q)
                    S_RUN: begin
                        if (hazard) state_q <= S_STALL;
                    end
                    S_STALL: begin
                        if (!hazard) state_q <= S_RUN;
                    end
                    S_FLUSH: begin
                        // Leave once the decremented count would reach 1.
                        if (int'(flush_cnt_q) <= 2) begin
                            state_q     <= S_RUN;
                            flush_cnt_q <= '0;
                        end else begin
                            flush_cnt_q <= flush_cnt_q - FL_W'(1);
                        end
                    end
                    default: state_q <= S_RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_issue_ctrl.sv
// Randomized and directed bench for cpu_issue_ctrl against a timestamp-based reference model.
module tb_cpu_issue_ctrl;
    import cpu_issue_ctrl_pkg::*;

    localparam int FLUSH_CYCLES = 2;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         dec_valid_i;
    logic [4:0]   dec_ra_i, dec_rb_i, dec_rd_i;
    logic         dec_ra_used_i, dec_rb_used_i, dec_rd_wr_i;
    instr_class_t dec_class_i;
    logic         flush_req_i;
    logic         issue_fire_o, issue_stall_o, bubble_o, flush_active_o;
    logic [15:0]  stall_cnt_o;

    cpu_issue_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .dec_valid_i    (dec_valid_i),
        .dec_ra_i       (dec_ra_i),
        .dec_ra_used_i  (dec_ra_used_i),
        .dec_rb_i       (dec_rb_i),
        .dec_rb_used_i  (dec_rb_used_i),
        .dec_rd_i       (dec_rd_i),
        .dec_rd_wr_i    (dec_rd_wr_i),
        .dec_class_i    (dec_class_i),
        .flush_req_i    (flush_req_i),
        .issue_fire_o   (issue_fire_o),
        .issue_stall_o  (issue_stall_o),
        .bubble_o       (bubble_o),
        .flush_active_o (flush_active_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: absolute cycle at which each register's pending write is visible.
    int wb_cycle [32];
    int flush_end = -1;
    int t = 0;
    int exp_sc = 0;
    logic obs_fire, obs_fa, obs_bubble;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    function automatic int tb_lat(input int c);
        int l;
        case (c)
            1: l = 3;
            2: l = 5;
            3: l = 4;
            default: l = 0;
        endcase
`ifdef CPU_FORWARDING_EN
        if (l != 0) l = l - 3;
`endif
        return l;
    endfunction

    function automatic int remaining(input int r);
        if (r == 0 || wb_cycle[r] <= t) return 0;
        return wb_cycle[r] - t;
    endfunction

    task automatic tick();
        bit flushing, busy_a, busy_b, waw, hazard, e_fire, e_stall, e_fa;
        int l;
        @(negedge clk_i);
        l        = tb_lat(int'(dec_class_i));
        flushing = (t <= flush_end);
        busy_a   = dec_ra_used_i && remaining(int'(dec_ra_i)) > 0;
        busy_b   = dec_rb_used_i && remaining(int'(dec_rb_i)) > 0;
        waw      = dec_rd_wr_i && remaining(int'(dec_rd_i)) > l;
        hazard   = dec_valid_i && (busy_a || busy_b || waw);
        e_fire   = !rst_i && dec_valid_i && !hazard && !flushing && !flush_req_i;
        e_stall  = !rst_i && (hazard || flushing || flush_req_i);
        e_fa     = !rst_i && (flushing || flush_req_i);
        check("issue_fire", 32'(issue_fire_o), 32'(e_fire));
        check("issue_stall", 32'(issue_stall_o), 32'(e_stall));
        check("bubble", 32'(bubble_o), 32'(!e_fire));
        check("flush_active", 32'(flush_active_o), 32'(e_fa));
        if (!rst_i) check("stall_cnt", 32'(stall_cnt_o), 32'(exp_sc));
        obs_fire   = issue_fire_o;
        obs_fa     = flush_active_o;
        obs_bubble = bubble_o;
        @(posedge clk_i);
        if (rst_i) begin
            for (int i = 0; i < 32; i++) wb_cycle[i] = 0;
            flush_end = -1;
            exp_sc    = 0;
        end else begin
            if (hazard && !flushing && exp_sc < 65535) exp_sc++;
            if (flush_req_i) flush_end = t + ((FLUSH_CYCLES > 2) ? FLUSH_CYCLES - 1 : 1);
            if (e_fire && dec_rd_wr_i && dec_rd_i != 5'd0) wb_cycle[dec_rd_i] = t + l + 1;
        end
        t++;
        #1;
    endtask

    task automatic set_instr(input instr_class_t c, input int rd, input bit rdw,
                             input int ra, input bit rau, input int rb, input bit rbu);
        dec_valid_i   = 1'b1;
        dec_class_i   = c;
        dec_rd_i      = 5'(rd);
        dec_rd_wr_i   = rdw;
        dec_ra_i      = 5'(ra);
        dec_ra_used_i = rau;
        dec_rb_i      = 5'(rb);
        dec_rb_used_i = rbu;
    endtask

    task automatic idle();
        dec_valid_i = 1'b0; dec_rd_wr_i = 1'b0; dec_ra_used_i = 1'b0; dec_rb_used_i = 1'b0;
        dec_class_i = CLS_NONE; flush_req_i = 1'b0;
    endtask

    // Holds the current instruction until it fires; reports the stall cycles seen.
    task automatic issue_wait(input string tag, output int stalls);
        bit fired = 1'b0;
        stalls = 0;
        for (int i = 0; i < 20 && !fired; i++) begin
            tick();
            if (obs_fire) fired = 1'b1;
            else stalls++;
        end
        if (!fired) check({tag, "_timeout"}, 32'd0, 32'd1);
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    int n, sc0;

    initial begin
        for (int i = 0; i < 32; i++) wb_cycle[i] = 0;
        dec_ra_i = '0; dec_rb_i = '0; dec_rd_i = '0;
        #1;
        do_reset();
        check("reset_stall_cnt", 32'(stall_cnt_o), 32'd0);

        // 1: independent ADD fires at once; a reader of r5 waits the tracked latency.
        set_instr(CLS_ALU, 5, 1, 1, 1, 2, 1);
        tick();
        check("t1_fire", 32'(obs_fire), 32'd1);
        check("t1_stall_cnt", 32'(stall_cnt_o), 32'd0);
        idle();
        set_instr(CLS_ALU, 6, 1, 5, 1, 0, 0);
        issue_wait("t1_reader", n);
        check("t1_r5_wait", 32'(n), 32'(tb_lat(1)));

        // 2: ADD r3 then SUB reading r3.
        sc0 = int'(stall_cnt_o);
        set_instr(CLS_ALU, 3, 1, 1, 1, 2, 1);
        issue_wait("t2_prod", n);
        set_instr(CLS_ALU, 8, 1, 3, 1, 2, 1);
        issue_wait("t2_cons", n);
        check("t2_stalls", 32'(n), 32'(tb_lat(1)));
        check("t2_stall_cnt", 32'(int'(stall_cnt_o) - sc0), 32'(tb_lat(1)));

        // 3: LOAD r7 then ADD reading r7.
        set_instr(CLS_LOAD, 7, 1, 0, 0, 0, 0);
        issue_wait("t3_prod", n);
        set_instr(CLS_ALU, 11, 1, 0, 0, 7, 1);
        issue_wait("t3_cons", n);
        check("t3_stalls", 32'(n), 32'(tb_lat(3)));

        // 4: WAW, MUL r4 then ADD writing r4.
        set_instr(CLS_MUL, 4, 1, 0, 0, 0, 0);
        issue_wait("t4_prod", n);
        set_instr(CLS_ALU, 4, 1, 0, 0, 0, 0);
        issue_wait("t4_waw", n);
        check("t4_stalls", 32'(n), 32'd2);

        // 5: flush while stalled, then a second flush_req extends it.
        set_instr(CLS_MUL, 12, 1, 0, 0, 0, 0);
        issue_wait("t5_prod", n);
        set_instr(CLS_ALU, 13, 1, 12, 1, 0, 0);
        tick();
        flush_req_i = 1'b1;
        tick();
        check("t5_fa_req", 32'(obs_fa), 32'd1);
        check("t5_bubble_req", 32'(obs_bubble), 32'd1);
        set_instr(CLS_ALU, 10, 1, 11, 1, 0, 0);
        tick();
        check("t5_fa_reload", 32'(obs_fa), 32'd1);
        flush_req_i = 1'b0;
        tick();
        check("t5_fa_ext", 32'(obs_fa), 32'd1);
        check("t5_nofire_ext", 32'(obs_fire), 32'd0);
        tick();
        check("t5_fa_done", 32'(obs_fa), 32'd0);
        check("t5_fire_after", 32'(obs_fire), 32'd1);
        idle();
        repeat (6) tick();

        // 6: reset in the middle of a flush clears scoreboard and FSM.
        set_instr(CLS_MUL, 9, 1, 0, 0, 0, 0);
        issue_wait("t6_prod", n);
        flush_req_i = 1'b1;
        tick();
        flush_req_i = 1'b0;
        rst_i = 1'b1;
        tick();
        check("t6_fa_in_reset", 32'(obs_fa), 32'd0);
        rst_i = 1'b0;
        set_instr(CLS_ALU, 14, 1, 9, 1, 9, 1);
        tick();
        check("t6_fire_after_reset", 32'(obs_fire), 32'd1);
        idle();

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            rst_i         = ($urandom_range(0, 199) == 0);
            flush_req_i   = ($urandom_range(0, 19) == 0);
            dec_valid_i   = ($urandom_range(0, 9) < 8);
            dec_class_i   = instr_class_t'($urandom_range(0, 3));
            dec_ra_i      = 5'($urandom_range(0, 7));
            dec_rb_i      = 5'($urandom_range(0, 7));
            dec_rd_i      = 5'($urandom_range(0, 7));
            dec_ra_used_i = 1'($urandom_range(0, 1));
            dec_rb_used_i = 1'($urandom_range(0, 1));
            dec_rd_wr_i   = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst_i = 1'b0;
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
